prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 108 ++++++++++
 tb/tb_prog_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program memory loader that holds the CPU while it owns memory
module prog_loader #(
    parameter int Psize = 6,
    parameter int Isize = 24
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic             abort,
    input  logic [Psize-1:0] last_addr,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    input  logic [Psize-1:0] cpu_addr,
    output logic [Psize-1:0] mem_addr,
    output logic [Isize-1:0] mem_wdata,
    output logic             mem_we,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done
);

    localparam int NB = Isize / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [Psize-1:0] load_addr_q, load_addr_d;
    logic [Psize-1:0] last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [Isize-1:0] asm_q, asm_d;
    logic             accept;

    assign byte_ready = (state_q == RECV);
    // Abort wins over a byte arriving in the same cycle.
    assign accept     = byte_ready & byte_valid & ~abort;

    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RECV;
                    load_addr_d = '0;
                    cnt_d       = '0;
                    last_d      = last_addr;
                end
            end
            RECV: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    asm_d   = '0;
                end else if (accept) begin
                    asm_d = (asm_q << 8) | Isize'(byte_data);
                    if (cnt_q == CW'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            WRITE: begin
                // Stop on the last address rather than comparing after increment, so it never wraps.
                if (load_addr_q == last_q) begin
                    state_d = DONE;
                end else begin
                    load_addr_d = load_addr_q + Psize'(1);
                    state_d     = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            load_addr_q <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
        end
    end

    assign busy      = (state_q == RECV) || (state_q == WRITE);
    assign cpu_hold  = busy;
    assign done      = (state_q == DONE);
    assign mem_we    = (state_q == WRITE);
    assign mem_wdata = asm_q;
    assign mem_addr  = busy ? load_addr_q : cpu_addr;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed scoreboard bench for prog_loader
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        nReset;
    logic        start;
    logic        abort;
    logic [5:0]  last_addr;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [5:0]  cpu_addr;
    logic [5:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        busy;
    logic        done;

    typedef struct {
        logic [5:0]  a;
        logic [23:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  passed = 0;
    int  total = 0;
    int  wr_cnt = 0;
    int  nready = 0;
    int  hold_bad = 0;
    int  cyc = 0;

    prog_loader #(.Psize(6), .Isize(24)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .start      (start),
        .abort      (abort),
        .last_addr  (last_addr),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cpu_addr   (cpu_addr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (busy === 1'b1 && byte_ready !== 1'b1) nready++;
        if (busy === 1'b1 && cpu_hold !== 1'b1) hold_bad++;
        if (mem_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", 32'(mem_wdata), 32'(e.d));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [5:0] a, input logic [23:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [5:0] la);
        last_addr = la;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int   budget;
        logic rdy;
        budget = 0;
        byte_valid = 1'b1;
        byte_data = b;
        do begin
            rdy = byte_ready;
            tick(1);
            budget++;
        end while (!rdy && budget < 20);
        if (!rdy) chk("send_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
        tick(gap);
    endtask

    task automatic send_word(input logic [23:0] w, input int gap);
        send(w[23:16], gap);
        send(w[15:8], gap);
        send(w[7:0], gap);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0, w0, nr0;
        logic [23:0] d;

        nReset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        last_addr = '0;
        byte_valid = 1'b0;
        byte_data = '0;
        cpu_addr = 6'd5;
        tick(2);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd5);
        nReset = 1'b1;
        tick(1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Continuous two-instruction load
        push(6'd0, 24'h123456);
        push(6'd1, 24'hABCDEF);
        w0 = wr_cnt;
        hold_bad = 0;
        do_start(6'd1);
        c0 = cyc;
        chk("t1_hold_start", 32'(cpu_hold), 32'd1);
        send_word(24'h123456, 0);
        send_word(24'hABCDEF, 0);
        wait_done(10);
        chk("t1_latency", 32'(cyc - c0), 32'd8);
        chk("t1_writes", 32'(wr_cnt - w0), 32'd2);
        chk("t1_hold_during", 32'(hold_bad), 32'd0);
        chk("t1_hold_after", 32'(cpu_hold), 32'd0);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Same stream with 3-cycle gaps, restarted from DONE
        push(6'd0, 24'h123456);
        push(6'd1, 24'hABCDEF);
        w0 = wr_cnt;
        nr0 = nready;
        do_start(6'd1);
        send_word(24'h123456, 3);
        send_word(24'hABCDEF, 3);
        wait_done(10);
        chk("t2_writes", 32'(wr_cnt - w0), 32'd2);
        chk("t2_notready_only_write", 32'(nready - nr0), 32'd2);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Abort after a partial second word
        push(6'd0, 24'h112233);
        w0 = wr_cnt;
        do_start(6'd3);
        send_word(24'h112233, 0);
        send(8'h44, 0);
        byte_valid = 1'b1;
        byte_data = 8'h55;
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        byte_valid = 1'b0;
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_hold", 32'(cpu_hold), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_ready", 32'(byte_ready), 32'd0);
        tick(3);
        chk("t3_writes", 32'(wr_cnt - w0), 32'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t3_idle_abort_busy", 32'(busy), 32'd0);
        chk("t3_idle_abort_done", 32'(done), 32'd0);
        push(6'd0, 24'h010203);
        do_start(6'd0);
        send_word(24'h010203, 0);
        wait_done(10);
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        cpu_addr = 6'd9;
        #1;
        chk("t3_done_abort_done", 32'(done), 32'd1);
        chk("t3_done_mem_addr", 32'(mem_addr), 32'd9);

        // Start pulsed mid-RECV is ignored
        push(6'd0, 24'hA1B2C3);
        push(6'd1, 24'hD4E5F6);
        w0 = wr_cnt;
        do_start(6'd1);
        send(8'hA1, 0);
        last_addr = 6'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_load_addr", 32'(mem_addr), 32'd0);
        send(8'hB2, 0);
        send(8'hC3, 0);
        send_word(24'hD4E5F6, 0);
        wait_done(10);
        chk("t4_writes", 32'(wr_cnt - w0), 32'd2);
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // Full memory, no wrap
        w0 = wr_cnt;
        do_start(6'd63);
        for (int i = 0; i < 64; i++) begin
            d = 24'($urandom);
            push(6'(i), d);
            send_word(d, 0);
        end
        wait_done(10);
        chk("t5_writes", 32'(wr_cnt - w0), 32'd64);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
        chk("t5_done", 32'(done), 32'd1);
        tick(2);
        chk("t5_no_extra", 32'(wr_cnt - w0), 32'd64);
        cpu_addr = 6'd42;
        #1;
        chk("t5_mem_addr_cpu", 32'(mem_addr), 32'd42);

        // Reset asserted during WRITE
        do_start(6'd2);
        send_word(24'h5A5A5A, 0);
        chk("t6_in_write", 32'(mem_we), 32'd1);
        w0 = wr_cnt;
        nReset = 1'b0;
        #1;
        chk("t6_we", 32'(mem_we), 32'd0);
        chk("t6_hold", 32'(cpu_hold), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_mem_addr", 32'(mem_addr), 32'd42);
        tick(1);
        nReset = 1'b1;
        tick(1);
        chk("t6_no_write", 32'(wr_cnt - w0), 32'd0);
        push(6'd0, 24'h778899);
        do_start(6'd0);
        send_word(24'h778899, 0);
        wait_done(10);
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
